// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DataRAM port arbiter.
//   arb_state_t : arbiter FSM states (RUN, FORCE, HALT)
//   rd_owner_t  : owner tag of a read in flight (OWN_CPU / OWN_DBG)
//   DRAM_ADDR_W : DataRAM word-address width (64 words)
//   WAIT_CNT_W  : width of the debug starvation counter
package dram_arb_pkg;

  localparam int DRAM_ADDR_W = 6;
  localparam int WAIT_CNT_W  = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FORCE = 2'd1,
    HALT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } rd_owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles the debug port was denied.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   inc        : debug request denied this cycle
//   clr        : clear (debug served, idle, or halt requested); wins over inc
//   expired    : this cycle's denial brings the count to MAX_WAIT, so the
//                next cycle must be a forced debug slot
module arb_wait_counter
  import dram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] count_reg;
  logic [WAIT_CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != MAX_CNT)) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Looking at the incoming count (rather than the stored one) lets the
  // FORCE slot follow the MAX_WAIT-th denial directly, giving a period of
  // MAX_WAIT+1 cycles under continuous contention.
  assign expired = inc && !clr && (count_next == MAX_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single-port DataRAM between the CPU MEM stage and a
// debug/loader port. One access per cycle; read data returns one cycle
// after the grant, tagged to its owner.
// Ports:
//   clk, reset                  : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       : CPU MEM-stage access
//   cpu_stall                   : CPU request present but not granted
//   cpu_rdata/cpu_rvalid        : CPU read return
//   dbg_req/we/addr/wdata       : debug/loader access
//   dbg_halt                    : request exclusive RAM ownership
//   dbg_gnt                     : debug access accepted this cycle
//   dbg_rdata/dbg_rvalid        : debug read return
//   halted                      : arbiter is in HALT
//   ram_addr/ram_din/ram_we     : to DataRAM
//   ram_dout                    : DataRAM registered read data
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W   = DRAM_ADDR_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic              dbg_halt,
  output logic              dbg_gnt,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_rvalid,
  output logic              halted,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout
);

  arb_state_t state_reg;
  arb_state_t state_next;
  logic       rd_pending_reg;
  rd_owner_t  rd_owner_reg;

  logic cpu_gnt_raw;
  logic dbg_gnt_raw;
  logic cpu_gnt;
  logic wait_inc;
  logic wait_clr;
  logic wait_expired;

  // Starvation guard. A halt request also clears it so that a simultaneous
  // halt/force condition leaves the counter at zero.
  assign wait_inc = dbg_req & ~dbg_gnt;
  assign wait_clr = ~dbg_req | dbg_gnt | dbg_halt;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .inc     (wait_inc),
    .clr     (wait_clr),
    .expired (wait_expired)
  );

  // Next state and grants.
  always_comb begin
    state_next  = state_reg;
    cpu_gnt_raw = 1'b0;
    dbg_gnt_raw = 1'b0;
    case (state_reg)
      RUN: begin
        cpu_gnt_raw = cpu_req;
        dbg_gnt_raw = dbg_req & ~cpu_req;
        if (wait_expired) begin
          state_next = FORCE;
        end
      end
      FORCE: begin
        dbg_gnt_raw = dbg_req;
        state_next  = RUN;
      end
      HALT: begin
        dbg_gnt_raw = dbg_req;
        state_next  = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
    // Halt overrides any other transition, including a pending FORCE.
    if (dbg_halt) begin
      state_next = HALT;
    end
  end

  // Grants and stall are combinational, so they are masked while reset is
  // held to keep the RAM and pipeline quiet.
  assign cpu_gnt   = cpu_gnt_raw & reset;
  assign dbg_gnt   = dbg_gnt_raw & reset;
  assign cpu_stall = cpu_req & ~cpu_gnt & reset;
  assign halted    = (state_reg == HALT);

  // RAM port mux; CPU values are presented whenever debug is not granted.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_wdata;
    ram_we   = cpu_we & cpu_gnt;
    if (dbg_gnt) begin
      ram_addr = dbg_addr;
      ram_din  = dbg_wdata;
      ram_we   = dbg_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= RUN;
      rd_pending_reg <= 1'b0;
      rd_owner_reg   <= OWN_CPU;
    end else begin
      state_reg      <= state_next;
      rd_pending_reg <= (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);
      rd_owner_reg   <= dbg_gnt ? OWN_DBG : OWN_CPU;
    end
  end

  // Read return: data is passed straight through, rvalid tells the owner.
  assign cpu_rvalid = rd_pending_reg & (rd_owner_reg == OWN_CPU);
  assign dbg_rvalid = rd_pending_reg & (rd_owner_reg == OWN_DBG);
  assign cpu_rdata  = ram_dout;
  assign dbg_rdata  = ram_dout;

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;

  localparam int AW   = 6;
  localparam int MAXW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_stall, cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          dbg_req, dbg_we, dbg_halt, dbg_gnt, dbg_rvalid, halted;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata, dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din, ram_dout;
  logic          ram_we;

  int checks = 0;
  int errors = 0;

  dram_port_arbiter #(.ADDR_W(AW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_halt(dbg_halt), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .halted(halted), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // DataRAM: 64 x 32, synchronous read
  logic [31:0] ram_mem [64] = '{default: 32'h0};
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  // Reference model: who owns the current cycle, plus expected read return
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  bit          m_halted = 0, m_force = 0;
  int          m_streak = 0;
  bit          m_ret_valid = 0, m_ret_dbg = 0;
  logic [31:0] m_ret_data = '0;
  bit          e_cpu_gnt = 0, e_dbg_gnt = 0, e_stall = 0, e_ram_we = 0;

  function automatic void model_eval();
    e_cpu_gnt = cpu_req && !m_halted && !m_force;
    e_dbg_gnt = dbg_req && (m_halted || m_force || !cpu_req);
    e_stall   = cpu_req && !e_cpu_gnt;
    e_ram_we  = (e_cpu_gnt && cpu_we) || (e_dbg_gnt && dbg_we);
  endfunction

  task automatic model_reset();
    m_halted = 0; m_force = 0; m_streak = 0;
    m_ret_valid = 0; m_ret_dbg = 0; m_ret_data = '0;
    model_eval();
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic [AW-1:0] daddr, input logic [31:0] dwd, input logic dhalt);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    dbg_halt = dhalt;
    model_eval();
  endtask

  task automatic drive_idle();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic step();
    bit in_run;
    @(posedge clk);
    in_run = !m_halted && !m_force;
    m_ret_valid = 0;
    if (e_cpu_gnt) begin
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else begin m_ret_valid = 1; m_ret_dbg = 0; m_ret_data = ref_mem[cpu_addr]; end
    end
    if (e_dbg_gnt) begin
      if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
      else begin m_ret_valid = 1; m_ret_dbg = 1; m_ret_data = ref_mem[dbg_addr]; end
    end
    if (dbg_halt) m_streak = 0;
    else if (dbg_req && !e_dbg_gnt) m_streak++;
    else m_streak = 0;
    m_force  = in_run && !dbg_halt && (m_streak >= MAXW);
    m_halted = dbg_halt;
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1, 1, 6'd5, 32'h1, 1, 1, 6'd7, 32'h2, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_stall, dbg_gnt, ram_we, cpu_rvalid, dbg_rvalid, halted} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000",
               {cpu_stall, dbg_gnt, ram_we, cpu_rvalid, dbg_rvalid, halted});
    end
    drive_idle();
    reset = 1'b1;
    model_reset();
    step();
    @(negedge clk);
    checks++;
    if ({halted, cpu_rvalid, dbg_rvalid, cpu_stall} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release got %b exp 0000", {halted, cpu_rvalid, dbg_rvalid, cpu_stall});
    end
    step();
  endtask

  task automatic test_write_read();
    drive(1, 1, 6'd5, 32'hDEADBEEF, 0, 0, '0, '0, 0);
    @(negedge clk);
    checks++;
    if ({ram_we, cpu_stall} !== 2'b10 || ram_addr !== 6'd5 || ram_din !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_cycle got we=%b stall=%b addr=%0d din=%h exp we=1 stall=0 addr=5 din=deadbeef",
               ram_we, cpu_stall, ram_addr, ram_din);
    end
    step();
    drive(1, 0, 6'd5, '0, 0, 0, '0, '0, 0);
    @(negedge clk);
    checks++;
    if ({ram_we, cpu_stall, cpu_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL rd_cycle got we=%b stall=%b rvalid=%b exp 0 0 0", ram_we, cpu_stall, cpu_rvalid);
    end
    step();
    drive_idle();
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dbg_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_return got cpu_rvalid=%b rdata=%h dbg_rvalid=%b exp 1 deadbeef 0",
               cpu_rvalid, cpu_rdata, dbg_rvalid);
    end
    step();
  endtask

  task automatic test_dbg_read();
    drive(0, 0, '0, '0, 1, 1, 6'd3, 32'hA5A50003, 0);
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 6'd3) begin
      errors++;
      $display("FAIL dbg_write got gnt=%b we=%b addr=%0d exp 1 1 3", dbg_gnt, ram_we, ram_addr);
    end
    step();
    drive(0, 0, '0, '0, 1, 0, 6'd3, '0, 0);
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || ram_we !== 1'b0 || dbg_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL dbg_read_gnt got gnt=%b we=%b rvalid=%b exp 1 0 0", dbg_gnt, ram_we, dbg_rvalid);
    end
    step();
    drive_idle();
    @(negedge clk);
    checks++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hA5A50003 || cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL dbg_read_ret got rvalid=%b rdata=%h cpu_rvalid=%b exp 1 a5a50003 0",
               dbg_rvalid, dbg_rdata, cpu_rvalid);
    end
    step();
  endtask

  // Continuous contention: debug is served every (MAXW+1)-th cycle.
  task automatic test_starvation();
    for (int c = 1; c <= 3 * (MAXW + 1); c++) begin
      bit exp_d, exp_dv;
      drive(1, 0, AW'(c), '0, 1, 0, AW'(c + 20), '0, 0);
      exp_d  = (c % (MAXW + 1)) == 0;
      exp_dv = (c > 1) && (((c - 1) % (MAXW + 1)) == 0);
      @(negedge clk);
      checks++;
      if (dbg_gnt !== exp_d || cpu_stall !== exp_d) begin
        errors++;
        $display("FAIL starve_gnt cyc=%0d got gnt=%b stall=%b exp %b %b", c, dbg_gnt, cpu_stall, exp_d, exp_d);
      end
      checks++;
      if (dbg_rvalid !== exp_dv || cpu_rvalid !== (c > 1 && !exp_dv)) begin
        errors++;
        $display("FAIL starve_ret cyc=%0d got dbg_rvalid=%b cpu_rvalid=%b exp %b %b",
                 c, dbg_rvalid, cpu_rvalid, exp_dv, (c > 1 && !exp_dv));
      end
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic test_halt();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, AW'(i), '0, 0, 0, '0, '0, i == 3);
      @(negedge clk);
      checks++;
      if (cpu_stall !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL halt_pre i=%0d got stall=%b halted=%b exp 0 0", i, cpu_stall, halted);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 6'd10, '0, 1, 1, AW'(i), 32'hC0DE0000 + i, 1);
      @(negedge clk);
      checks++;
      if ({halted, cpu_stall, dbg_gnt, ram_we} !== 4'b1111 || ram_addr !== AW'(i)) begin
        errors++;
        $display("FAIL halt_wr i=%0d got h/s/g/we=%b addr=%0d exp 1111 addr=%0d",
                 i, {halted, cpu_stall, dbg_gnt, ram_we}, ram_addr, i);
      end
      if (i == 0) begin
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA5A50003) begin
          errors++;
          $display("FAIL halt_inflight got rvalid=%b rdata=%h exp 1 a5a50003", cpu_rvalid, cpu_rdata);
        end
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 6'd10, '0, 1, 0, AW'(i), '0, 1);
      @(negedge clk);
      checks++;
      if (cpu_stall !== 1'b1 || dbg_gnt !== 1'b1 || dbg_rvalid !== (i > 0) ||
          (i > 0 && dbg_rdata !== 32'hC0DE0000 + i - 1)) begin
        errors++;
        $display("FAIL halt_rd i=%0d got stall=%b gnt=%b rvalid=%b rdata=%h exp 1 1 %b %h",
                 i, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata, (i > 0), 32'hC0DE0000 + i - 1);
      end
      step();
    end
    drive(1, 0, 6'd10, '0, 0, 0, '0, '0, 0);
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || cpu_stall !== 1'b1 || dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hC0DE0003) begin
      errors++;
      $display("FAIL halt_drop got halted=%b stall=%b rvalid=%b rdata=%h exp 1 1 1 c0de0003",
               halted, cpu_stall, dbg_rvalid, dbg_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL halt_resume got halted=%b stall=%b exp 0 0", halted, cpu_stall);
    end
    step();
    drive_idle();
    step();
  endtask

  task automatic test_random();
    logic rh = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(15) == 0) rh = ~rh;
      drive($urandom_range(9) < 7, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom,
            $urandom_range(9) < 6, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom, rh);
      @(negedge clk);
      checks++;
      if ({cpu_stall, dbg_gnt, ram_we, halted} !== {e_stall, e_dbg_gnt, e_ram_we, m_halted}) begin
        errors++;
        $display("FAIL rnd_ctrl cyc=%0d got stall/gnt/we/halted=%b exp %b", c,
                 {cpu_stall, dbg_gnt, ram_we, halted}, {e_stall, e_dbg_gnt, e_ram_we, m_halted});
      end
      checks++;
      if (ram_addr !== (e_dbg_gnt ? dbg_addr : cpu_addr) || ram_din !== (e_dbg_gnt ? dbg_wdata : cpu_wdata)) begin
        errors++;
        $display("FAIL rnd_mux cyc=%0d got addr=%0d din=%h exp addr=%0d din=%h", c, ram_addr, ram_din,
                 e_dbg_gnt ? dbg_addr : cpu_addr, e_dbg_gnt ? dbg_wdata : cpu_wdata);
      end
      checks++;
      if (cpu_rvalid !== (m_ret_valid && !m_ret_dbg) || dbg_rvalid !== (m_ret_valid && m_ret_dbg) ||
          (m_ret_valid && (m_ret_dbg ? dbg_rdata : cpu_rdata) !== m_ret_data)) begin
        errors++;
        $display("FAIL rnd_ret cyc=%0d got cpu_rv=%b dbg_rv=%b data=%h exp cpu_rv=%b dbg_rv=%b data=%h",
                 c, cpu_rvalid, dbg_rvalid, m_ret_dbg ? dbg_rdata : cpu_rdata,
                 m_ret_valid && !m_ret_dbg, m_ret_valid && m_ret_dbg, m_ret_data);
      end
      step();
    end
    drive_idle();
    repeat (2) step();
  endtask

  task automatic test_reset_mid_read();
    // Debug read granted, reset lands while its return is pending.
    drive(0, 0, '0, '0, 1, 0, 6'd3, '0, 0);
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_rd_gnt got %b exp 1", dbg_gnt);
    end
    step();
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({dbg_rvalid, cpu_rvalid, dbg_gnt, ram_we, cpu_stall, halted} !== 6'b0) begin
      errors++;
      $display("FAIL rst_async got %b exp 000000",
               {dbg_rvalid, cpu_rvalid, dbg_gnt, ram_we, cpu_stall, halted});
    end
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    model_reset();
    step();
    @(negedge clk);
    checks++;
    if ({dbg_rvalid, cpu_rvalid, halted} !== 3'b0) begin
      errors++;
      $display("FAIL rst_no_ret got %b exp 000", {dbg_rvalid, cpu_rvalid, halted});
    end
    step();
    // Partial starvation streak, then reset: a fresh MAXW denials are needed.
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, AW'(c), '0, 1, 0, 6'd1, '0, 0);
      step();
    end
    drive(1, 0, 6'd0, '0, 1, 0, 6'd1, '0, 1);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({dbg_gnt, cpu_stall, ram_we} !== 3'b0) begin
      errors++;
      $display("FAIL rst_gate got gnt/stall/we=%b exp 000", {dbg_gnt, cpu_stall, ram_we});
    end
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    model_reset();
    step();
    for (int c = 1; c <= MAXW + 1; c++) begin
      drive(1, 0, AW'(c), '0, 1, 0, 6'd2, '0, 0);
      @(negedge clk);
      checks++;
      if (dbg_gnt !== (c == MAXW + 1) || halted !== 1'b0) begin
        errors++;
        $display("FAIL rst_counter cyc=%0d got gnt=%b halted=%b exp %b 0", c, dbg_gnt, halted, (c == MAXW + 1));
      end
      step();
    end
    drive_idle();
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dbg_read();
    test_starvation();
    test_halt();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
